// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the seven-segment readback logic.
package seven_segment_pkg;

   localparam int unsigned SEG_W    = 7;
   localparam int unsigned NIBBLE_W = 4;

   // Active-low cathode patterns, bit0=a .. bit6=g
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [NIBBLE_W-1:0] NIBBLE_BLANK   = 4'hF;
   localparam logic [NIBBLE_W-1:0] NIBBLE_ILLEGAL = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_e;

   typedef struct packed {
      logic [NIBBLE_W-1:0] nibble;
      logic                blank;
      logic                illegal;
   } seg_dec_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational segment-pattern to BCD decoder with blank/illegal flags.
module seven_segment_decoder
   import seven_segment_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output seg_dec_t         dec_c_o
);

   always_comb begin
      dec_c_o.nibble  = NIBBLE_ILLEGAL;
      dec_c_o.blank   = 1'b0;
      dec_c_o.illegal = 1'b0;
      case (seg_i)
         SEG_0:     dec_c_o.nibble = 4'h0;
         SEG_1:     dec_c_o.nibble = 4'h1;
         SEG_2:     dec_c_o.nibble = 4'h2;
         SEG_3:     dec_c_o.nibble = 4'h3;
         SEG_4:     dec_c_o.nibble = 4'h4;
         SEG_5:     dec_c_o.nibble = 4'h5;
         SEG_6:     dec_c_o.nibble = 4'h6;
         SEG_7:     dec_c_o.nibble = 4'h7;
         SEG_8:     dec_c_o.nibble = 4'h8;
         SEG_9:     dec_c_o.nibble = 4'h9;
         SEG_BLANK: begin
            dec_c_o.nibble = NIBBLE_BLANK;
            dec_c_o.blank  = 1'b1;
         end
         default:   dec_c_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Reconstructs the BCD word from a multiplexed active-low segment/anode bus.
// Optional decimal-point capture is enabled by SEVEN_SEGMENT_CAPTURE_DP_EN.
module seven_segment_capture
   import seven_segment_pkg::*;
#(
   parameter int unsigned SEGMENT_NUM   = 8,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned STABLE_FRAMES = 2
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic [SEG_W-1:0]         i_Segments,
   input  logic [SEGMENT_NUM-1:0]   i_Anodes,
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
   input  logic                     i_DP,
   output logic [SEGMENT_NUM-1:0]   o_DP_Mask,
`endif
   output logic [4*SEGMENT_NUM-1:0] o_BCD_Num,
   output logic [SEGMENT_NUM-1:0]   o_Blank_Mask,
   output logic                     o_Valid,
   output logic                     o_Error
);

   localparam int unsigned WORD_W  = 4 * SEGMENT_NUM;
   localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned MATCH_W = $clog2(STABLE_FRAMES + 1);

   logic dp_raw;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
   assign dp_raw = i_DP;
`else
   assign dp_raw = 1'b1;
`endif

   logic [SEGMENT_NUM-1:0] in_an_q, cur_an_q, cur_an_d, samp_an;
   logic [SEG_W-1:0]       in_seg_q, cur_seg_q, cur_seg_d, samp_seg;
   logic                   in_dp_q, cur_dp_q, cur_dp_d, samp_dp;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SEGMENT_NUM-1:0] seen_q, seen_d, sel, seen_new;
   logic [WORD_W-1:0]      buf_nib_q, buf_nib_d, prev_nib_q, prev_nib_d, pub_nib_q, pub_nib_d, frame_nib;
   logic [SEGMENT_NUM-1:0] buf_blank_q, buf_blank_d, prev_blank_q, prev_blank_d, pub_blank_q, pub_blank_d, frame_blank;
   logic [SEGMENT_NUM-1:0] buf_dp_q, buf_dp_d, prev_dp_q, prev_dp_d, pub_dp_q, pub_dp_d, frame_dp;
   logic [MATCH_W-1:0]     match_q, match_d;
   logic                   pub_flag_q, pub_flag_d, valid_q, valid_d, err_q, err_d;
   logic                   an_single, an_gap, an_multi, changed, load, sample;
   seg_dec_t               dec;

   assign an_single = $onehot(~in_an_q);
   assign an_gap    = &in_an_q;
   assign an_multi  = !an_single && !an_gap;
   assign changed   = (in_an_q != cur_an_q) || (in_seg_q != cur_seg_q) || (in_dp_q != cur_dp_q);

   seven_segment_decoder u_decoder (
      .seg_i   (samp_seg),
      .dec_c_o (dec)
   );

   // Capture FSM: settle on a digit, sample it once, then hold until the anode moves
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_an_d  = cur_an_q;
      cur_seg_d = cur_seg_q;
      cur_dp_d  = cur_dp_q;
      load      = 1'b0;
      sample    = 1'b0;
      if (an_multi) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   load = an_single;
            ST_SETTLE: begin
               if (!changed) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == CNT_W'(SETTLE_CYCLES)) begin
                     sample  = 1'b1;
                     state_d = ST_HOLD;
                  end
               end else if (an_gap) begin
                  state_d = ST_IDLE;
               end else begin
                  load = 1'b1;
               end
            end
            ST_HOLD: begin
               if (in_an_q != cur_an_q) begin
                  if (an_gap) state_d = ST_IDLE;
                  else        load    = 1'b1;
               end
            end
            default:   state_d = ST_IDLE;
         endcase
      end
      if (load) begin
         cur_an_d  = in_an_q;
         cur_seg_d = in_seg_q;
         cur_dp_d  = in_dp_q;
         cnt_d     = CNT_W'(1);
         // A one-cycle settle window samples on the loading cycle itself
         if (SETTLE_CYCLES <= 1) begin
            sample  = 1'b1;
            state_d = ST_HOLD;
         end else begin
            state_d = ST_SETTLE;
         end
      end
      samp_an  = load ? in_an_q  : cur_an_q;
      samp_seg = load ? in_seg_q : cur_seg_q;
      samp_dp  = load ? in_dp_q  : cur_dp_q;
   end

   // Frame assembly, stability tracking and publish decision
   always_comb begin
      seen_d       = seen_q;
      buf_nib_d    = buf_nib_q;
      buf_blank_d  = buf_blank_q;
      buf_dp_d     = buf_dp_q;
      prev_nib_d   = prev_nib_q;
      prev_blank_d = prev_blank_q;
      prev_dp_d    = prev_dp_q;
      pub_nib_d    = pub_nib_q;
      pub_blank_d  = pub_blank_q;
      pub_dp_d     = pub_dp_q;
      match_d      = match_q;
      pub_flag_d   = pub_flag_q;
      valid_d      = 1'b0;
      err_d        = err_q | an_multi;
      sel          = ~samp_an;
      seen_new     = seen_q | sel;
      frame_nib    = buf_nib_q;
      frame_blank  = buf_blank_q;
      frame_dp     = buf_dp_q;
      for (int i = 0; i < SEGMENT_NUM; i++) begin
         if (sel[i]) begin
            frame_nib[4*i +: 4] = dec.nibble;
            frame_blank[i]      = dec.blank;
            frame_dp[i]         = ~samp_dp;
         end
      end
      if (sample) begin
         buf_nib_d   = frame_nib;
         buf_blank_d = frame_blank;
         buf_dp_d    = frame_dp;
         err_d       = err_d | dec.illegal;
         if (&seen_new) begin
            seen_d = '0;
            if ({frame_nib, frame_blank, frame_dp} == {prev_nib_q, prev_blank_q, prev_dp_q}) begin
               match_d = (match_q >= MATCH_W'(STABLE_FRAMES)) ? match_q : match_q + MATCH_W'(1);
            end else begin
               match_d      = MATCH_W'(1);
               prev_nib_d   = frame_nib;
               prev_blank_d = frame_blank;
               prev_dp_d    = frame_dp;
            end
            if ((match_d == MATCH_W'(STABLE_FRAMES)) &&
                (!pub_flag_q || ({frame_nib, frame_blank, frame_dp} != {pub_nib_q, pub_blank_q, pub_dp_q}))) begin
               valid_d     = 1'b1;
               pub_flag_d  = 1'b1;
               pub_nib_d   = frame_nib;
               pub_blank_d = frame_blank;
               pub_dp_d    = frame_dp;
            end
         end else begin
            seen_d = seen_new;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         in_an_q      <= '1;
         in_seg_q     <= SEG_BLANK;
         in_dp_q      <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_an_q     <= '1;
         cur_seg_q    <= SEG_BLANK;
         cur_dp_q     <= 1'b1;
         seen_q       <= '0;
         buf_nib_q    <= '0;
         buf_blank_q  <= '0;
         buf_dp_q     <= '0;
         prev_nib_q   <= '0;
         prev_blank_q <= '0;
         prev_dp_q    <= '0;
         pub_nib_q    <= '0;
         pub_blank_q  <= '0;
         pub_dp_q     <= '0;
         match_q      <= '0;
         pub_flag_q   <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         in_an_q      <= i_Anodes;
         in_seg_q     <= i_Segments;
         in_dp_q      <= dp_raw;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_an_q     <= cur_an_d;
         cur_seg_q    <= cur_seg_d;
         cur_dp_q     <= cur_dp_d;
         seen_q       <= seen_d;
         buf_nib_q    <= buf_nib_d;
         buf_blank_q  <= buf_blank_d;
         buf_dp_q     <= buf_dp_d;
         prev_nib_q   <= prev_nib_d;
         prev_blank_q <= prev_blank_d;
         prev_dp_q    <= prev_dp_d;
         pub_nib_q    <= pub_nib_d;
         pub_blank_q  <= pub_blank_d;
         pub_dp_q     <= pub_dp_d;
         match_q      <= match_d;
         pub_flag_q   <= pub_flag_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
      end
   end

   assign o_BCD_Num    = pub_nib_q;
   assign o_Blank_Mask = pub_blank_q;
   assign o_Valid      = valid_q;
   assign o_Error      = err_q;
`ifdef SEVEN_SEGMENT_CAPTURE_DP_EN
   assign o_DP_Mask    = pub_dp_q;
`endif

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side counterpart of the seven-segment display driver. Samples the multiplexed active-low segment/anode bus and reconstructs the per-digit BCD word the driver was given. Publishes a new word only after it has been seen unchanged for a configurable number of full scan frames. Used in the board-level bench and in loopback self-test to read back displayed time/alarm values without probing internal counters.

## Interface
- SEGMENT_NUM, 8, number of digits/anodes scanned
- SETTLE_CYCLES, 4, consecutive identical cycles required before a digit is sampled (min 1)
- STABLE_FRAMES, 2, consecutive identical complete frames required before publishing (min 1)

- i_Clk  in  1  design clock (5 MHz domain)
- i_Reset  in  1  synchronous, active-low reset
- i_Segments  in  7  cathodes, active-low, bit0=a … bit6=g
- i_Anodes  in  SEGMENT_NUM  anode enables, active-low, bit k = digit k
- o_BCD_Num  out  4*SEGMENT_NUM  published word, digit k in bits [4k+3:4k]
- o_Blank_Mask  out  SEGMENT_NUM  bit k set when digit k was all-off in published frame
- o_Valid  out  1  one-cycle pulse when o_BCD_Num/o_Blank_Mask update
- o_Error  out  1  sticky: illegal segment pattern or multi-hot anode seen

## Operation
- Anode classes: single-low (exactly one 0) = digit k; all-ones = gap; anything else = multi-hot.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: on single-low anode, load settle counter with 1 and register anode/segments, go to SETTLE.
  - SETTLE: if anode and segments are unchanged, count up. At count == SETTLE_CYCLES, decode the digit into slot k, set seen[k], go to HOLD. On any change, restart the count with the new values; if the new anode is gap, go to IDLE.
  - HOLD: wait for an anode change. On change to single-low, go to SETTLE with count 1. On change to gap, go to IDLE.
  - Multi-hot in any state: set o_Error, go to IDLE, keep the frame buffer.
- Decode (active-low, {g..a}):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 7'h7F = blank: nibble 4'hF, blank bit 1.
  - Any other pattern: nibble 4'hE, set o_Error.
- Frame complete when seen is all ones. On the same cycle as the last sample:
  - Compare the new frame (nibbles + blank bits) with the previous complete frame.
  - Equal: match_cnt++, saturating at STABLE_FRAMES. Different: match_cnt=1 and store as previous.
  - Clear seen.
- Publish when match_cnt reaches STABLE_FRAMES and the frame differs from the published value, or when nothing has been published since reset.
- Re-sampling a digit already in seen overwrites its slot; this does not complete a frame.
- o_Error clears only on reset.

## Timing
- Reset values: o_BCD_Num=0, o_Blank_Mask=0, o_Valid=0, o_Error=0. Internal state: FSM=IDLE, seen=0, match_cnt=0, published-flag=0.
- Reset mid-scan discards the partial frame; capture restarts from IDLE the next cycle.
- Digit sample occurs on the cycle the settle count reaches SETTLE_CYCLES, i.e. SETTLE_CYCLES-1 cycles after the anode edge is registered.
- o_Valid and the new o_BCD_Num/o_Blank_Mask appear together, 1 cycle after the sample that completes the publishing frame.
- A repeated identical frame produces no further o_Valid.
- Inputs are registered once internally; the bench must drive them synchronously to i_Clk.

## Configuration
- SEVEN_SEGMENT_CAPTURE_DP_EN defined:
  - Adds input i_DP (1, active-low) and output o_DP_Mask (SEGMENT_NUM, reset 0).
  - DP is sampled with the segments, participates in the settle/stability comparisons, and is published alongside o_BCD_Num.
- Undefined: no DP ports; the decimal point is ignored entirely.

## Structure
- Package seven_segment_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - NIBBLE_BLANK=4'hF and NIBBLE_ILLEGAL=4'hE
  - FSM state typedef
- Sub-module seven_segment_decoder: combinational, 7-bit pattern -> {nibble, blank, illegal}. It is shared with any later segment-readback logic.

## Test plan
- Driver scan of 32'h1234_5659, all settle windows ≥4 cycles, STABLE_FRAMES=2 -> single o_Valid at end of frame 2 with o_BCD_Num=32'h12345659, o_Blank_Mask=0, o_Error=0.
- Same word for 5 more frames -> no further o_Valid. Change digit 0 to 0 (7'h40) -> o_Valid after 2 frames, o_BCD_Num=32'h12345650.
- Digit 7 blank (7'h7F) -> o_BCD_Num[31:28]=4'hF, o_Blank_Mask=8'h80.
- Segment glitch shorter than SETTLE_CYCLES during digit 3 -> no effect on capture. Pattern 7'h7E held -> o_Error=1, nibble 4'hE, o_Error remains set after clean frames.
- Anodes 8'hFC for one cycle -> o_Error=1, partial frame kept. Reset low mid-frame -> all outputs 0 and the next publish needs 2 full frames.
- With SEVEN_SEGMENT_CAPTURE_DP_EN defined, DP low on digit 2 -> o_DP_Mask=8'h04 at publish.
